c1541_sd_server: RTL

Serves the sector-level SD handshake of the 1541 track buffer from a byte-wide disk-image store. It sits directly upstream of the track buffer on the `sd_clk` side. On each `sd_rd` or `sd_wr` request it streams one 512-byte block between the image store and the track buffer's SD port, then releases `sd_ack`. It replaces the host-side SD emulation when the D64 image is held in local memory (BRAM/SDRAM).

---
 rtl/c1541_pkg.sv | 18 +
 rtl/c1541_sd_server.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/c1541_pkg.sv
// Shared definitions for the 1541 SD block server.
// Holds the server FSM state type and the sector / D64 image size constants.
package c1541_pkg;

    localparam int unsigned SECTOR_BYTES = 512;
    localparam int unsigned D64_BYTES    = 174848;

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdPut,
        StWrAddr,
        StWrLat,
        StWrReq,
        StDone
    } state_e;

endpackage

// File: rtl/c1541_sd_server.sv
// Serves 512-byte SD block requests from the 1541 track buffer out of a local
// byte-wide disk-image store.
//
// Ports:
//   sd_clk, reset            clock and synchronous active-high reset
//   sd_lba, sd_rd, sd_wr     block request from the track buffer (levels)
//   sd_ack                   high for the whole block transfer
//   sd_buff_addr/dout/wr     byte write port into the track buffer
//   sd_buff_din              track buffer read data (registered read)
//   mem_addr/rd/wr/dout      request to the image store, held until mem_ack
//   mem_din, mem_ack         image store read data and completion strobe
//   oob                      one-cycle pulse after a block touching bytes past the image
module c1541_sd_server
    import c1541_pkg::*;
#(
    parameter int unsigned IMG_BYTES = D64_BYTES,
    parameter int unsigned ADDR_W    = 18
) (
    input  logic              sd_clk,
    input  logic              reset,
    input  logic [31:0]       sd_lba,
    input  logic              sd_rd,
    input  logic              sd_wr,
    output logic              sd_ack,
    output logic [8:0]        sd_buff_addr,
    output logic [7:0]        sd_buff_dout,
    output logic              sd_buff_wr,
    input  logic [7:0]        sd_buff_din,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        mem_dout,
    input  logic [7:0]        mem_din,
    input  logic              mem_ack,
    output logic              oob
);

    localparam logic [8:0] LAST_IDX = 9'(SECTOR_BYTES - 1);

    // A byte is out of range if the LBA cannot be addressed at all, or the
    // full byte address lies beyond the image.
    function automatic logic byte_oob(input logic [31:0] lba, input logic [8:0] idx);
        logic [40:0] full;
        full = {lba, idx};
        return ((lba >> (ADDR_W - 9)) != 32'd0) || (full >= 41'(IMG_BYTES));
    endfunction

    function automatic logic [ADDR_W-1:0] byte_addr(input logic [31:0] lba,
                                                    input logic [8:0]  idx);
        return ADDR_W'({lba, idx});
    endfunction

    state_e            state_q, state_d;
    logic              armed_q, armed_d;
    logic [31:0]       lba_q, lba_d;
    logic [8:0]        idx_q, idx_d;
    logic              oob_seen_q, oob_seen_d;
    logic              sd_ack_q, sd_ack_d;
    logic [8:0]        sd_buff_addr_q, sd_buff_addr_d;
    logic [7:0]        sd_buff_dout_q, sd_buff_dout_d;
    logic              sd_buff_wr_q, sd_buff_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              oob_q, oob_d;

    // Byte entry helpers: the case below selects which byte is entered next,
    // the shared tail issues the per-byte setup.
    logic              start_rd, start_wr, finish;
    logic [31:0]       ent_lba;
    logic [8:0]        ent_idx;
    logic              ent_oob;
    logic [ADDR_W-1:0] ent_addr;
    logic              cur_oob;
    logic [ADDR_W-1:0] cur_addr;

    assign cur_oob  = byte_oob(lba_q, idx_q);
    assign cur_addr = byte_addr(lba_q, idx_q);

    always_comb begin
        state_d        = state_q;
        armed_d        = armed_q;
        lba_d          = lba_q;
        idx_d          = idx_q;
        oob_seen_d     = oob_seen_q;
        sd_ack_d       = sd_ack_q;
        sd_buff_addr_d = sd_buff_addr_q;
        sd_buff_dout_d = sd_buff_dout_q;
        sd_buff_wr_d   = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_rd_d       = mem_rd_q;
        mem_wr_d       = mem_wr_q;
        mem_dout_d     = mem_dout_q;
        oob_d          = 1'b0;
        start_rd       = 1'b0;
        start_wr       = 1'b0;
        finish         = 1'b0;
        ent_lba        = lba_q;
        ent_idx        = idx_q + 9'd1;

        // A low request level re-arms; a held level is never accepted twice.
        if (!sd_rd && !sd_wr) begin
            armed_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (armed_q && (sd_rd || sd_wr)) begin
                    lba_d      = sd_lba;
                    idx_d      = 9'd0;
                    sd_ack_d   = 1'b1;
                    armed_d    = 1'b0;
                    oob_seen_d = 1'b0;
                    ent_lba    = sd_lba;
                    ent_idx    = 9'd0;
                    if (sd_wr) begin
                        start_wr = 1'b1;
                    end else begin
                        start_rd = 1'b1;
                    end
                end
            end
            StRdReq: begin
                if (mem_ack) begin
                    mem_rd_d       = 1'b0;
                    sd_buff_dout_d = mem_din;
                    sd_buff_addr_d = idx_q;
                    sd_buff_wr_d   = 1'b1;
                    state_d        = StRdPut;
                end
            end
            StRdPut: begin
                if (idx_q == LAST_IDX) begin
                    finish = 1'b1;
                end else begin
                    idx_d    = idx_q + 9'd1;
                    start_rd = 1'b1;
                end
            end
            StWrAddr: begin
                state_d = StWrLat;
            end
            StWrLat: begin
                mem_dout_d = sd_buff_din;
                if (cur_oob) begin
                    oob_seen_d = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        finish = 1'b1;
                    end else begin
                        idx_d    = idx_q + 9'd1;
                        start_wr = 1'b1;
                    end
                end else begin
                    mem_wr_d   = 1'b1;
                    mem_addr_d = cur_addr;
                    state_d    = StWrReq;
                end
            end
            StWrReq: begin
                if (mem_ack) begin
                    mem_wr_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        finish = 1'b1;
                    end else begin
                        idx_d    = idx_q + 9'd1;
                        start_wr = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        ent_oob  = byte_oob(ent_lba, ent_idx);
        ent_addr = byte_addr(ent_lba, ent_idx);

        // Out-of-range read bytes bypass memory and deliver zero directly.
        if (start_rd) begin
            if (ent_oob) begin
                oob_seen_d     = 1'b1;
                sd_buff_addr_d = ent_idx;
                sd_buff_dout_d = 8'h00;
                sd_buff_wr_d   = 1'b1;
                state_d        = StRdPut;
            end else begin
                mem_rd_d   = 1'b1;
                mem_addr_d = ent_addr;
                state_d    = StRdReq;
            end
        end

        if (start_wr) begin
            sd_buff_addr_d = ent_idx;
            state_d        = StWrAddr;
        end

        // sd_ack drops and oob pulses in the DONE cycle itself.
        if (finish) begin
            sd_ack_d = 1'b0;
            oob_d    = oob_seen_d;
            state_d  = StDone;
        end
    end

    always_ff @(posedge sd_clk) begin
        if (reset) begin
            state_q        <= StIdle;
            armed_q        <= 1'b0;
            lba_q          <= '0;
            idx_q          <= '0;
            oob_seen_q     <= 1'b0;
            sd_ack_q       <= 1'b0;
            sd_buff_addr_q <= '0;
            sd_buff_dout_q <= '0;
            sd_buff_wr_q   <= 1'b0;
            mem_addr_q     <= '0;
            mem_rd_q       <= 1'b0;
            mem_wr_q       <= 1'b0;
            mem_dout_q     <= '0;
            oob_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            armed_q        <= armed_d;
            lba_q          <= lba_d;
            idx_q          <= idx_d;
            oob_seen_q     <= oob_seen_d;
            sd_ack_q       <= sd_ack_d;
            sd_buff_addr_q <= sd_buff_addr_d;
            sd_buff_dout_q <= sd_buff_dout_d;
            sd_buff_wr_q   <= sd_buff_wr_d;
            mem_addr_q     <= mem_addr_d;
            mem_rd_q       <= mem_rd_d;
            mem_wr_q       <= mem_wr_d;
            mem_dout_q     <= mem_dout_d;
            oob_q          <= oob_d;
        end
    end

    assign sd_ack       = sd_ack_q;
    assign sd_buff_addr = sd_buff_addr_q;
    assign sd_buff_dout = sd_buff_dout_q;
    assign sd_buff_wr   = sd_buff_wr_q;
    assign mem_addr     = mem_addr_q;
    assign mem_rd       = mem_rd_q;
    assign mem_wr       = mem_wr_q;
    assign mem_dout     = mem_dout_q;
    assign oob          = oob_q;

endmodule
